// File: rtl/poly_tone_generator.sv
// Multi-channel square-wave tone generator driven by ASCII note commands.
// Each channel runs its own half-period counter; outputs are masked by a global enable.
module poly_tone_generator #(
    parameter int CLK_HZ   = 50000000,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int CNT_W    = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [CH_W-1:0]     note_ch,
    input  logic [6:0]          note_ascii,
    input  logic                note_on,
    input  logic [1:0]          octave,
    input  logic                enable,
    output logic [CHANNELS-1:0] tone,
    output logic [CHANNELS-1:0] active,
    output logic                speaker,
    output logic [CH_W:0]       mix_level,
    output logic                err
);

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_W = CNT_W'(CLK_HZ / (2 * 1108));
    localparam logic [CNT_W-1:0] HALF_E = CNT_W'(CLK_HZ / (2 * 1244));
    localparam logic [CNT_W-1:0] HALF_T = CNT_W'(CLK_HZ / (2 * 1478));
    localparam logic [CNT_W-1:0] HALF_Y = CNT_W'(CLK_HZ / (2 * 1660));
    localparam logic [CNT_W-1:0] HALF_U = CNT_W'(CLK_HZ / (2 * 932));
    localparam logic [CNT_W-1:0] HALF_A = CNT_W'(CLK_HZ / (2 * 1046));
    localparam logic [CNT_W-1:0] HALF_S = CNT_W'(CLK_HZ / (2 * 1174));
    localparam logic [CNT_W-1:0] HALF_D = CNT_W'(CLK_HZ / (2 * 1318));
    localparam logic [CNT_W-1:0] HALF_F = CNT_W'(CLK_HZ / (2 * 1396));
    localparam logic [CNT_W-1:0] HALF_G = CNT_W'(CLK_HZ / (2 * 1566));
    localparam logic [CNT_W-1:0] HALF_H = CNT_W'(CLK_HZ / (2 * 880));
    localparam logic [CNT_W-1:0] HALF_J = CNT_W'(CLK_HZ / (2 * 988));

    // Returns {known, half}; unknown codes come back as all zeros.
    function automatic logic [CNT_W:0] key_lookup(input logic [6:0] code);
        logic [CNT_W:0] r;
        r = '0;
        case (code)
            7'h57:   r = {1'b1, HALF_W};
            7'h45:   r = {1'b1, HALF_E};
            7'h54:   r = {1'b1, HALF_T};
            7'h59:   r = {1'b1, HALF_Y};
            7'h55:   r = {1'b1, HALF_U};
            7'h41:   r = {1'b1, HALF_A};
            7'h53:   r = {1'b1, HALF_S};
            7'h44:   r = {1'b1, HALF_D};
            7'h46:   r = {1'b1, HALF_F};
            7'h47:   r = {1'b1, HALF_G};
            7'h48:   r = {1'b1, HALF_H};
            7'h4A:   r = {1'b1, HALF_J};
            default: r = '0;
        endcase
        return r;
    endfunction

    // A zero half-period would never toggle, so clamp it to one cycle.
    function automatic logic [CNT_W-1:0] shift_half(input logic [CNT_W-1:0] h,
                                                    input logic [1:0]       oct);
        logic [CNT_W-1:0] s;
        s = h >> oct;
        if (s == '0) s = ONE;
        return s;
    endfunction

    logic                vld_p0;
    logic [CH_W-1:0]     ch_p0;
    logic                on_p0;
    logic                known_p0;
    logic [CNT_W-1:0]    half_p0;
    logic                accept;
    logic                ch_ok;
    logic [CNT_W:0]      lookup;
    logic [CNT_W-1:0]    cnt    [CHANNELS];
    logic [CNT_W-1:0]    half_q [CHANNELS];
    logic [CHANNELS-1:0] tone_q;

    assign note_ready = ~vld_p0;
    assign accept     = note_valid & ~vld_p0;
    assign lookup     = key_lookup(note_ascii);
    assign ch_ok      = vld_p0 && (int'(ch_p0) < CHANNELS);

    // Stage p0: command capture at the accept edge
    always_ff @(posedge clk) begin
        if (reset) vld_p0 <= 1'b0;
        else       vld_p0 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ch_p0    <= note_ch;
            on_p0    <= note_on;
            known_p0 <= lookup[CNT_W];
            half_p0  <= shift_half(lookup[CNT_W-1:0], octave);
        end
    end

    // Stage p1: apply the captured command, or advance each channel counter
    always_ff @(posedge clk) begin
        if (reset) err <= 1'b0;
        else       err <= ch_ok & on_p0 & ~known_p0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= '0;
            tone_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]    <= '0;
                half_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_ok && int'(ch_p0) == i) begin
                    if (on_p0 && known_p0) begin
                        active[i] <= 1'b1;
                        tone_q[i] <= 1'b1;
                        half_q[i] <= half_p0;
                        cnt[i]    <= half_p0 - ONE;
                    end else begin
                        active[i] <= 1'b0;
                        tone_q[i] <= 1'b0;
                        cnt[i]    <= '0;
                    end
                end else if (active[i]) begin
                    if (cnt[i] == '0) begin
                        tone_q[i] <= ~tone_q[i];
                        cnt[i]    <= half_q[i] - ONE;
                    end else begin
                        cnt[i] <= cnt[i] - ONE;
                    end
                end else begin
                    tone_q[i] <= 1'b0;
                    cnt[i]    <= '0;
                end
            end
        end
    end

    assign tone    = tone_q & active & {CHANNELS{enable}};
    assign speaker = |tone;

    always_comb begin
        mix_level = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix_level = mix_level + {{CH_W{1'b0}}, tone[i]};
        end
    end

endmodule
